// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b cache types and the victim entry record
//   lc3b_c_tag   : 9-bit cache tag
//   lc3b_c_index : 3-bit set index
//   lc3b_c_line  : 128-bit cache line
//   wb_entry     : one queued victim {tag, index, line}
//   wb_address   : physical byte address of a line from its tag and index
package lc3b_types;

  typedef logic [8:0]   lc3b_c_tag;
  typedef logic [2:0]   lc3b_c_index;
  typedef logic [127:0] lc3b_c_line;

  typedef struct packed {
    lc3b_c_tag   tag;
    lc3b_c_index index;
    lc3b_c_line  line;
  } wb_entry;

  function automatic logic [15:0] wb_address(input lc3b_c_tag tag, input lc3b_c_index index);
    return {tag, index, 4'b0000};
  endfunction

endpackage

// File: rtl/cache_writeback_buffer_if.sv
// rtl/cache_writeback_buffer_if.sv - victim buffer bus: evict, pmem write and snoop groups
//   evict_*  : victim offer from the cache controller (valid/ready handshake)
//   pmem_*   : write request to physical memory, completed by one-cycle pmem_resp
//   snoop_*  : lookup of a pending miss against queued victims
//   empty    : no victims queued
//   master   : environment side (cache controller + physical memory)
//   slave    : the writeback buffer
interface cache_writeback_buffer_if;
  import lc3b_types::*;

  logic        evict_valid;
  logic        evict_ready;
  lc3b_c_tag   evict_tag;
  lc3b_c_index evict_index;
  lc3b_c_line  evict_line;

  logic        pmem_write;
  logic [15:0] pmem_address;
  lc3b_c_line  pmem_wdata;
  logic        pmem_resp;

  lc3b_c_tag   snoop_tag;
  lc3b_c_index snoop_index;
  logic        snoop_hit;
  lc3b_c_line  snoop_line;

  logic        empty;

  modport master (
    output evict_valid, evict_tag, evict_index, evict_line, pmem_resp, snoop_tag, snoop_index,
    input  evict_ready, pmem_write, pmem_address, pmem_wdata, snoop_hit, snoop_line, empty
  );

  modport slave (
    input  evict_valid, evict_tag, evict_index, evict_line, pmem_resp, snoop_tag, snoop_index,
    output evict_ready, pmem_write, pmem_address, pmem_wdata, snoop_hit, snoop_line, empty
  );

endinterface

// File: rtl/cache_wb_match.sv
// rtl/cache_wb_match.sv - youngest-match search over the queued victims
//   entries : storage array, indexed by slot
//   head    : slot of the oldest valid entry
//   count   : number of valid entries starting at head
//   tag/index : lookup key
//   hit     : at least one valid entry matches tag and index
//   line    : line of the youngest matching entry (0 when no hit)
module cache_wb_match
  import lc3b_types::*;
#(
  parameter int DEPTH = 2
) (
  input  wb_entry                    entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]   head,
  input  logic [$clog2(DEPTH):0]     count,
  input  lc3b_c_tag                  tag,
  input  lc3b_c_index                index,
  output logic                       hit,
  output lc3b_c_line                 line
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] slot;

  // Walk from oldest to youngest by age; a later match overwrites an earlier
  // one, so the youngest match is what remains.
  always_comb begin
    hit  = 1'b0;
    line = '0;
    slot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head + PW'(k);
      if ((CW'(k) < count) && (entries[slot].tag == tag) && (entries[slot].index == index)) begin
        hit  = 1'b1;
        line = entries[slot].line;
      end
    end
  end

endmodule

// File: rtl/cache_writeback_buffer.sv
// rtl/cache_writeback_buffer.sv - victim writeback FIFO draining dirty lines to pmem
//   clk   : clock, all state on posedge
//   reset : synchronous active-high reset
//   bus   : cache_writeback_buffer_if.slave (evict, pmem and snoop groups, empty)
//   DEPTH : number of victim entries, power of two, >= 2
//   CACHE_WB_SNOOP_EN : when defined, builds the snoop search; otherwise snoop outputs are 0
module cache_writeback_buffer
  import lc3b_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  cache_writeback_buffer_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    S_IDLE,
    S_WRITE
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  wb_entry       mem_q [DEPTH];
  wb_entry       mem_d [DEPTH];

  logic evict_ready;
  logic push;
  logic pop;

  // Ready looks only at the registered count, so a pop this cycle never
  // frees room for this cycle's offer.
  assign evict_ready = (count_q < CW'(DEPTH));
  assign push        = bus.evict_valid && evict_ready;
  assign pop         = (state_q == S_WRITE) && bus.pmem_resp;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    mem_d   = mem_q;

    case (state_q)
      S_IDLE:  if (count_q != '0) state_d = S_WRITE;
      S_WRITE: if (bus.pmem_resp) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      mem_d[tail_q] = '{tag: bus.evict_tag, index: bus.evict_index, line: bus.evict_line};
      tail_d        = tail_q + PW'(1);
    end
    if (pop) begin
      head_d = head_q + PW'(1);
    end

    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payloads need no reset; validity is carried by head/count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.evict_ready  = evict_ready;
  assign bus.pmem_write   = (state_q == S_WRITE);
  assign bus.pmem_address = wb_address(mem_q[head_q].tag, mem_q[head_q].index);
  assign bus.pmem_wdata   = mem_q[head_q].line;
  assign bus.empty        = (count_q == '0);

`ifdef CACHE_WB_SNOOP_EN
  cache_wb_match #(.DEPTH(DEPTH)) u_match (
    .entries (mem_q),
    .head    (head_q),
    .count   (count_q),
    .tag     (bus.snoop_tag),
    .index   (bus.snoop_index),
    .hit     (bus.snoop_hit),
    .line    (bus.snoop_line)
  );
`else
  // Without snoop the controller must wait for empty before any fill.
  logic unused_snoop;
  assign unused_snoop   = ^{bus.snoop_tag, bus.snoop_index};
  assign bus.snoop_hit  = 1'b0;
  assign bus.snoop_line = '0;
`endif

endmodule

// File: tb/tb_cache_writeback_buffer.sv
// tb/tb_cache_writeback_buffer.sv - self-checking bench for cache_writeback_buffer
module tb_cache_writeback_buffer;
  import lc3b_types::*;

  localparam int DEPTH = 2;
  localparam logic [127:0] LINE_DB = 128'hDEAD0123456789ABCDEF01234567BEEF;
  localparam logic [127:0] LINE_A  = 128'h0A0A0A0A_11111111_22222222_33333333;
  localparam logic [127:0] LINE_B  = 128'h0B0B0B0B_44444444_55555555_66666666;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_writeback_buffer_if bus();

  cache_writeback_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: the queue holds victims oldest first; m_wr says a write
  // is on the bus (starts the cycle after the queue was seen non-empty while
  // not writing, ends on the response edge).
  wb_entry mq[$];
  bit      m_wr = 1'b0;

  always @(posedge clk) begin : model
    int sz;
    bit acc;
    bit pp;
    wb_entry e;
    if (reset) begin
      mq.delete();
      m_wr = 1'b0;
    end else begin
      sz  = mq.size();
      acc = bus.evict_valid && (sz < DEPTH);
      pp  = m_wr && bus.pmem_resp;
      if (pp) mq.delete(0);
      if (acc) begin
        e.tag   = bus.evict_tag;
        e.index = bus.evict_index;
        e.line  = bus.evict_line;
        mq.push_back(e);
      end
      if (pp) m_wr = 1'b0;
      else if (!m_wr && sz > 0) m_wr = 1'b1;
    end
  end

  always @(negedge clk) begin : compare
    bit         s_hit;
    logic [127:0] s_line;
    if (chk_en) begin
      check("evict_ready", bus.evict_ready, (mq.size() < DEPTH));
      check("empty", bus.empty, (mq.size() == 0));
      check("pmem_write", bus.pmem_write, m_wr);
      if (m_wr && mq.size() > 0) begin
        check("pmem_address", bus.pmem_address, {mq[0].tag, mq[0].index, 4'b0000});
        check("pmem_wdata", bus.pmem_wdata, mq[0].line);
      end
      s_hit  = 1'b0;
      s_line = '0;
`ifdef CACHE_WB_SNOOP_EN
      foreach (mq[i]) begin
        if (mq[i].tag == bus.snoop_tag && mq[i].index == bus.snoop_index) begin
          s_hit  = 1'b1;
          s_line = mq[i].line;
        end
      end
`endif
      check("snoop_hit", bus.snoop_hit, s_hit);
      if (s_hit || !bus.snoop_hit) check("snoop_line", bus.snoop_line, s_line);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input lc3b_c_tag t, input lc3b_c_index i, input lc3b_c_line l);
    bus.evict_valid = 1'b1;
    bus.evict_tag   = t;
    bus.evict_index = i;
    bus.evict_line  = l;
  endtask

  task automatic wait_write(output logic [15:0] addr);
    bit ok;
    ok = 1'b0;
    addr = '0;
    for (int n = 0; n < 50; n++) begin
      if (bus.pmem_write) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("wait_write_timeout", ok, 1'b1);
    if (ok) addr = bus.pmem_address;
  endtask

  task automatic drain_one(output logic [15:0] addr);
    wait_write(addr);
    bus.pmem_resp = 1'b1;
    tick();
    bus.pmem_resp = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a0;
    logic [15:0] a1;

    bus.evict_valid = 1'b0;
    bus.evict_tag   = '0;
    bus.evict_index = '0;
    bus.evict_line  = '0;
    bus.pmem_resp   = 1'b0;
    bus.snoop_tag   = '0;
    bus.snoop_index = '0;
    reset = 1'b1;
    tick();
    tick();
    chk_en = 1'b1;
    check("reset_ready", bus.evict_ready, 1'b1);
    check("reset_empty", bus.empty, 1'b1);
    check("reset_write", bus.pmem_write, 1'b0);
    check("reset_snoop", bus.snoop_hit, 1'b0);
    reset = 1'b0;
    tick();

    // Single victim
    offer(9'h1A5, 3'd3, LINE_DB);
    tick();
    bus.evict_valid = 1'b0;
    check("single_write_early", bus.pmem_write, 1'b0);
    check("single_not_empty", bus.empty, 1'b0);
    tick();
    check("single_write_asserted", bus.pmem_write, 1'b1);
    check("single_address", bus.pmem_address, 16'hD2B0);
    for (int n = 0; n < 4; n++) begin
      check("single_wdata_stable", bus.pmem_wdata, LINE_DB);
      check("single_write_held", bus.pmem_write, 1'b1);
      if (n < 3) tick();
    end
    bus.pmem_resp = 1'b1;
    tick();
    bus.pmem_resp = 1'b0;
    check("single_empty_after", bus.empty, 1'b1);
    check("single_write_after", bus.pmem_write, 1'b0);
    tick();

    // Fill to DEPTH, offer a third
    offer(9'h011, 3'd1, LINE_A);
    tick();
    offer(9'h022, 3'd2, LINE_B);
    tick();
    offer(9'h033, 3'd3, LINE_DB);
    check("full_ready_low", bus.evict_ready, 1'b0);
    tick();
    bus.evict_valid = 1'b0;
    drain_one(a0);
    drain_one(a1);
    check("full_order_first", a0, {9'h011, 3'd1, 4'b0000});
    check("full_order_second", a1, {9'h022, 3'd2, 4'b0000});
    tick();
    check("full_third_dropped", bus.empty, 1'b1);

    // Enqueue on the same edge as the head retires, enough times to wrap
    offer(9'h100, 3'd0, LINE_A);
    tick();
    bus.evict_valid = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      wait_write(a0);
      check("wrap_head_address", a0, {9'(9'h100 + i), 3'(i), 4'b0000});
      bus.pmem_resp = 1'b1;
      offer(9'(9'h101 + i), 3'(i + 1), {4{32'(i)}});
      tick();
      bus.pmem_resp   = 1'b0;
      bus.evict_valid = 1'b0;
      check("wrap_count_kept", bus.empty, 1'b0);
    end
    drain_one(a0);
    tick();

    // Two victims with the same key: youngest wins
    bus.snoop_tag   = 9'h003;
    bus.snoop_index = 3'd5;
    offer(9'h003, 3'd5, LINE_A);
    tick();
    offer(9'h003, 3'd5, LINE_B);
    tick();
    bus.evict_valid = 1'b0;
`ifdef CACHE_WB_SNOOP_EN
    check("snoop_dup_hit", bus.snoop_hit, 1'b1);
    check("snoop_dup_line", bus.snoop_line, LINE_B);
`else
    check("snoop_off_hit", bus.snoop_hit, 1'b0);
    check("snoop_off_line", bus.snoop_line, 128'h0);
`endif
    drain_one(a0);
    drain_one(a1);
    check("snoop_retired_hit", bus.snoop_hit, 1'b0);
    tick();

    // Reset in the middle of a write
    offer(9'h0AA, 3'd2, LINE_A);
    tick();
    offer(9'h0BB, 3'd4, LINE_B);
    tick();
    bus.evict_valid = 1'b0;
    wait_write(a0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_write", bus.pmem_write, 1'b0);
    check("rst_mid_empty", bus.empty, 1'b1);
    check("rst_mid_ready", bus.evict_ready, 1'b1);
    bus.pmem_resp = 1'b1;
    tick();
    bus.pmem_resp = 1'b0;
    check("stray_resp_empty", bus.empty, 1'b1);
    check("stray_resp_write", bus.pmem_write, 1'b0);
    tick();

    // Random traffic with small key space so snoops collide
    for (int c = 0; c < 600; c++) begin
      bus.evict_valid = 1'($urandom_range(0, 1));
      bus.evict_tag   = 9'($urandom_range(0, 3));
      bus.evict_index = 3'($urandom_range(0, 1));
      bus.evict_line  = {$urandom, $urandom, $urandom, $urandom};
      bus.pmem_resp   = ($urandom_range(0, 3) == 0);
      bus.snoop_tag   = 9'($urandom_range(0, 3));
      bus.snoop_index = 3'($urandom_range(0, 1));
      reset           = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0;
    bus.evict_valid = 1'b0;
    bus.pmem_resp   = 1'b0;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
